// File: rtl/issue_ctrl_pkg.sv
// Shared types and opcode helpers for the front-end issue controller.
// The buffered fetch entry layout is defined once here so FIFO and control agree on it.
package issue_ctrl_pkg;

    localparam logic [6:0] LOAD_OP  = 7'b0000011;
    localparam logic [6:0] STORE_OP = 7'b0100011;

    typedef struct packed {
        logic        pred_taken;
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic is_mem_op(input logic [31:0] inst);
        return (inst[6:0] == LOAD_OP) || (inst[6:0] == STORE_OP);
    endfunction

endpackage

// File: rtl/issue_ctrl_fifo.sv
// Circular instruction buffer: DEPTH entries, push/pop/clear, occupancy count.
// Storage is reset so the head read port never shows X.
module inst_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointer, count and storage update; clear discards any same-edge push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr <= rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({push, pop})
                2'b10:   count <= count + {{PTR_W{1'b0}}, 1'b1};
                2'b01:   count <= count - {{PTR_W{1'b0}}, 1'b1};
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: buffers fetched instructions and releases the head to decode
// only when downstream resources can take it; a flush drains and blocks issue briefly.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int PTR_W        = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_fetch_valid,
    input  logic [31:0]      in_fetch_inst,
    input  logic [31:0]      in_fetch_pc,
    input  logic             in_fetch_pred_taken,
    output logic             out_fetch_ready,
    input  logic             in_rob_full,
    input  logic             in_rs_full,
    input  logic             in_lsq_full,
    input  logic             in_flush,
    output logic             out_decode_ena,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_pc,
    output logic             out_pred_taken,
    output logic             out_stall,
    output logic [PTR_W:0]   out_count
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    localparam int               CNT_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD     = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] rec_cnt;
    logic [CNT_W-1:0] rec_cnt_nxt;
    logic             ready;
    logic             ready_nxt;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic             push;
    logic             pop;
    logic             issue_ok;
    fetch_entry_t     head;
    fetch_entry_t     wr_entry;
    logic [ENTRY_W-1:0] head_raw;

    assign wr_entry = '{pred_taken: in_fetch_pred_taken, pc: in_fetch_pc, inst: in_fetch_inst};
    assign push     = in_fetch_valid && ready;
    assign pop      = issue_ok;

    inst_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (in_flush),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head_raw),
        .count (count)
    );

    assign head = fetch_entry_t'(head_raw);

    // Issue gate: the ROB/RS/LSQ full flags already leave one slot of slack for decode latency.
    always_comb begin
        issue_ok = 1'b0;
        if ((state == ST_RUN) && !in_flush && (count != '0)) begin
            issue_ok = !in_rob_full && !in_rs_full && !(is_mem_op(head.inst) && in_lsq_full);
        end else begin
            issue_ok = 1'b0;
        end
    end

    // Flush/recovery sequencing: FLUSH itself is the first blocked cycle after in_flush falls.
    always_comb begin
        state_nxt   = state;
        rec_cnt_nxt = rec_cnt;
        if (in_flush) begin
            state_nxt = ST_FLUSH;
        end else begin
            case (state)
                ST_RUN: state_nxt = ST_RUN;
                ST_FLUSH: begin
                    if (RELOAD == '0) begin
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt   = ST_RECOVER;
                        rec_cnt_nxt = RELOAD;
                    end
                end
                ST_RECOVER: begin
                    if ((rec_cnt == '0) || (rec_cnt == CNT_W'(1))) begin
                        state_nxt   = ST_RUN;
                        rec_cnt_nxt = '0;
                    end else begin
                        rec_cnt_nxt = rec_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt   = ST_RUN;
                    rec_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Fetch-ready is computed one edge ahead so the output is a plain flop.
    always_comb begin
        count_nxt = count;
        if (in_flush) begin
            count_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_nxt = count + {{PTR_W{1'b0}}, 1'b1};
                2'b01:   count_nxt = count - {{PTR_W{1'b0}}, 1'b1};
                default: count_nxt = count;
            endcase
        end
        ready_nxt = (state_nxt == ST_RUN) && (count_nxt < FULL_COUNT);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            rec_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            rec_cnt <= rec_cnt_nxt;
            ready   <= ready_nxt;
        end
    end

    assign out_fetch_ready = ready;
    assign out_decode_ena  = issue_ok;
    assign out_inst        = head.inst;
    assign out_pc          = head.pc;
    assign out_pred_taken  = head.pred_taken;
    assign out_count       = count;
    assign out_stall       = (state == ST_RUN) && (count != '0) && !issue_ok && !in_flush;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: hand-computed expectations per cycle, checked mid-cycle.
module tb_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_fetch_valid;
    logic [31:0] in_fetch_inst;
    logic [31:0] in_fetch_pc;
    logic        in_fetch_pred_taken;
    logic        out_fetch_ready;
    logic        in_rob_full;
    logic        in_rs_full;
    logic        in_lsq_full;
    logic        in_flush;
    logic        out_decode_ena;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_pred_taken;
    logic        out_stall;
    logic [2:0]  out_count;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] ADDI = 32'h0000_0013;
    localparam logic [31:0] ADD  = 32'h0000_0033;
    localparam logic [31:0] LW   = 32'h0000_2003;
    localparam logic [31:0] SW   = 32'h0000_2023;

    issue_ctrl #(
        .DEPTH        (4),
        .PTR_W        (2),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_fetch_valid      (in_fetch_valid),
        .in_fetch_inst       (in_fetch_inst),
        .in_fetch_pc         (in_fetch_pc),
        .in_fetch_pred_taken (in_fetch_pred_taken),
        .out_fetch_ready     (out_fetch_ready),
        .in_rob_full         (in_rob_full),
        .in_rs_full          (in_rs_full),
        .in_lsq_full         (in_lsq_full),
        .in_flush            (in_flush),
        .out_decode_ena      (out_decode_ena),
        .out_inst            (out_inst),
        .out_pc              (out_pc),
        .out_pred_taken      (out_pred_taken),
        .out_stall           (out_stall),
        .out_count           (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        in_fetch_valid      = v;
        in_fetch_inst       = inst;
        in_fetch_pc         = pc;
        in_fetch_pred_taken = pc[2];
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        in_rob_full = 1'b0;
        in_rs_full  = 1'b0;
        in_lsq_full = 1'b0;
        in_flush    = 1'b0;

        // reset state
        #3;
        check("rst_ready", {31'd0, out_fetch_ready}, 32'd0);
        check("rst_count", {29'd0, out_count}, 32'd0);
        check("rst_ena", {31'd0, out_decode_ena}, 32'd0);
        check("rst_inst", out_inst, 32'd0);
        check("rst_stall", {31'd0, out_stall}, 32'd0);
        cyc(); cyc();
        mid();
        rst_n = 1'b1;
        cyc();
        check("ready_after_rst", {31'd0, out_fetch_ready}, 32'd1);

        // three ADDI pushes, all resources free
        drive(1'b1, ADDI, 32'h0);
        mid();
        check("t1_ena0", {31'd0, out_decode_ena}, 32'd0);
        cyc(); drive(1'b1, ADDI, 32'h4);
        mid();
        check("t1_ena1", {31'd0, out_decode_ena}, 32'd1);
        check("t1_pc1", out_pc, 32'h0);
        cyc(); drive(1'b1, ADDI, 32'h8);
        mid();
        check("t1_ena2", {31'd0, out_decode_ena}, 32'd1);
        check("t1_pc2", out_pc, 32'h4);
        check("t1_pred2", {31'd0, out_pred_taken}, 32'd1);
        cyc(); drive(1'b0, ADDI, 32'h0);
        mid();
        check("t1_ena3", {31'd0, out_decode_ena}, 32'd1);
        check("t1_pc3", out_pc, 32'h8);
        cyc();
        mid();
        check("t1_ena_end", {31'd0, out_decode_ena}, 32'd0);
        check("t1_count_end", {29'd0, out_count}, 32'd0);

        // fill to DEPTH with the ROB full, then drain with a concurrent push
        cyc(); in_rob_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ADDI, 32'h100 + 32'(4 * i));
            cyc();
        end
        drive(1'b1, ADDI, 32'h110);
        mid();
        check("t2_count4", {29'd0, out_count}, 32'd4);
        check("t2_ready_full", {31'd0, out_fetch_ready}, 32'd0);
        check("t2_stall", {31'd0, out_stall}, 32'd1);
        check("t2_no_ena", {31'd0, out_decode_ena}, 32'd0);
        cyc(); in_rob_full = 1'b0;
        mid();
        check("t2_ena_a", {31'd0, out_decode_ena}, 32'd1);
        check("t2_pc_a", out_pc, 32'h100);
        check("t2_ready_a", {31'd0, out_fetch_ready}, 32'd0);
        cyc();
        mid();
        check("t2_ready_b", {31'd0, out_fetch_ready}, 32'd1);
        check("t2_pc_b", out_pc, 32'h104);
        check("t2_count_b", {29'd0, out_count}, 32'd3);
        cyc(); drive(1'b0, ADDI, 32'h0);
        mid();
        check("t2_pc_c", out_pc, 32'h108);
        check("t2_count_c", {29'd0, out_count}, 32'd3);
        cyc();
        mid();
        check("t2_pc_d", out_pc, 32'h10c);
        cyc();
        mid();
        check("t2_pc_e", out_pc, 32'h110);
        check("t2_ena_e", {31'd0, out_decode_ena}, 32'd1);
        cyc();
        mid();
        check("t2_count_end", {29'd0, out_count}, 32'd0);

        // memory ops versus LSQ full
        in_lsq_full = 1'b1;
        drive(1'b1, LW, 32'h200);
        cyc(); drive(1'b0, ADDI, 32'h0);
        mid();
        check("t3_lw_ena", {31'd0, out_decode_ena}, 32'd0);
        check("t3_lw_stall", {31'd0, out_stall}, 32'd1);
        check("t3_lw_inst", out_inst, LW);
        cyc(); in_lsq_full = 1'b0;
        mid();
        check("t3_lw_issue", {31'd0, out_decode_ena}, 32'd1);
        check("t3_lw_nostall", {31'd0, out_stall}, 32'd0);
        cyc(); in_lsq_full = 1'b1;
        drive(1'b1, ADD, 32'h204);
        cyc(); drive(1'b0, ADDI, 32'h0);
        mid();
        check("t3_add_issue", {31'd0, out_decode_ena}, 32'd1);
        check("t3_add_pc", out_pc, 32'h204);
        cyc();
        drive(1'b1, SW, 32'h208);
        cyc(); drive(1'b0, ADDI, 32'h0);
        mid();
        check("t3_sw_ena", {31'd0, out_decode_ena}, 32'd0);
        cyc(); in_lsq_full = 1'b0; in_rs_full = 1'b1;
        mid();
        check("t3_rs_block", {31'd0, out_decode_ena}, 32'd0);
        check("t3_rs_stall", {31'd0, out_stall}, 32'd1);
        cyc(); in_rs_full = 1'b0;
        mid();
        check("t3_sw_issue", {31'd0, out_decode_ena}, 32'd1);
        cyc();

        // flush with three entries buffered
        in_rob_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ADDI, 32'h300 + 32'(4 * i));
            cyc();
        end
        drive(1'b0, ADDI, 32'h0);
        in_rob_full = 1'b0;
        in_flush    = 1'b1;
        mid();
        check("t4_count3", {29'd0, out_count}, 32'd3);
        check("t4_flush_ena", {31'd0, out_decode_ena}, 32'd0);
        check("t4_flush_stall", {31'd0, out_stall}, 32'd0);
        cyc(); in_flush = 1'b0;
        drive(1'b1, ADDI, 32'h400);
        mid();
        check("t4_count0", {29'd0, out_count}, 32'd0);
        check("t4_blk1_ready", {31'd0, out_fetch_ready}, 32'd0);
        cyc();
        mid();
        check("t4_blk2_ready", {31'd0, out_fetch_ready}, 32'd0);
        check("t4_blk2_count", {29'd0, out_count}, 32'd0);
        cyc(); drive(1'b0, ADDI, 32'h0);
        mid();
        check("t4_run_ready", {31'd0, out_fetch_ready}, 32'd1);
        check("t4_run_count", {29'd0, out_count}, 32'd0);
        check("t4_run_ena", {31'd0, out_decode_ena}, 32'd0);

        // steady push+pop through several pointer wraps
        drive(1'b1, ADDI, 32'h500);
        cyc();
        for (int i = 1; i <= 10; i++) begin
            if (i < 10) begin
                drive(1'b1, ADDI, 32'h500 + 32'(4 * i));
            end else begin
                drive(1'b0, ADDI, 32'h0);
            end
            mid();
            check("t5_count", {29'd0, out_count}, 32'd1);
            check("t5_ena", {31'd0, out_decode_ena}, 32'd1);
            check("t5_pc", out_pc, 32'h500 + 32'(4 * (i - 1)));
            cyc();
        end
        mid();
        check("t5_count_end", {29'd0, out_count}, 32'd0);

        // asynchronous reset in the middle of a drain
        cyc(); in_rob_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ADDI, 32'h600 + 32'(4 * i));
            cyc();
        end
        drive(1'b0, ADDI, 32'h0);
        in_rob_full = 1'b0;
        cyc();
        #2;
        check("t6_count2", {29'd0, out_count}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_count", {29'd0, out_count}, 32'd0);
        check("t6_rst_ready", {31'd0, out_fetch_ready}, 32'd0);
        check("t6_rst_ena", {31'd0, out_decode_ena}, 32'd0);
        check("t6_rst_pc", out_pc, 32'd0);
        check("t6_rst_inst", out_inst, 32'd0);
        cyc();
        mid();
        rst_n = 1'b1;
        cyc();
        mid();
        check("t6_post_ena", {31'd0, out_decode_ena}, 32'd0);
        check("t6_post_ready", {31'd0, out_fetch_ready}, 32'd1);
        cyc();
        mid();
        check("t6_post_ena2", {31'd0, out_decode_ena}, 32'd0);
        check("t6_post_count", {29'd0, out_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
